// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and FSM encoding for the TDM demultiplexer.
//   NUM_SLOTS - beats per frame (one per output channel)
//   SLOT_W    - width of the slot counter
//   state_e   - frame-alignment FSM states
package tdm_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit slot counter for the TDM demultiplexer.
// Ports:
//   clk, rst  - clock, async active-high reset
//   clr_i     - return to slot 0 (loss of sync)
//   load1_i   - sync beat captured as slot 0, next beat is slot 1
//   en_i      - advance by one slot (wraps 3 -> 0)
//   slot_o    - current slot number
// Priority: clr_i > load1_i > en_i.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load1_i,
  input  logic              en_i,
  output logic [SLOT_W-1:0] slot_o
);

  logic [SLOT_W-1:0] slot_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          slot_q <= '0;
    else if (clr_i)   slot_q <= '0;
    else if (load1_i) slot_q <= SLOT_W'(1);
    else if (en_i)    slot_q <= slot_q + 1'b1;
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: 1:4 time-division demultiplexer.
// Beat k of each fsync-aligned frame is written to channel k. A frame-coherent
// output buffer is built only when TDM_DEMUX_FRAME_EN is defined; otherwise
// frm_data/frm_vld are tied to 0.
// Ports:
//   clk, rst          - clock, async active-high reset
//   din, din_vld      - multiplexed beat and its valid
//   fsync             - beat is slot 0 (qualified by din_vld)
//   ch_data, ch_vld   - per-channel holding registers and update strobes
//   frm_data, frm_vld - complete aligned frame and its strobe
//   locked            - frame alignment held
//   sync_err          - one-cycle strobe on resync or loss of sync
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             din,
  input  logic                     din_vld,
  input  logic                     fsync,
  output logic [NUM_SLOTS*W-1:0]   ch_data,
  output logic [NUM_SLOTS-1:0]     ch_vld,
  output logic [NUM_SLOTS*W-1:0]   frm_data,
  output logic                     frm_vld,
  output logic                     locked,
  output logic                     sync_err
);

  state_e                          state_q;
  logic [SLOT_W-1:0]               slot;
  logic [NUM_SLOTS-1:0][W-1:0]     ch_q;
  logic [NUM_SLOTS-1:0]            ch_vld_q;
  logic                            sync_err_q;

  // Beat classification
  logic hunt_cap, resync, loss, normal, wr_en;
  logic [SLOT_W-1:0] wr_slot;

  always_comb begin
    hunt_cap = din_vld && (state_q == HUNT) && fsync;
    resync   = din_vld && (state_q == LOCKED) && fsync && (slot != '0);
    loss     = din_vld && (state_q == LOCKED) && !fsync && (slot == '0);
    normal   = din_vld && (state_q == LOCKED) && !resync && !loss;
    wr_en    = hunt_cap || resync || normal;
    // Sync captures always land in slot 0 regardless of the counter.
    wr_slot  = (hunt_cap || resync) ? '0 : slot;
  end

  tdm_slot_ctr u_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (loss),
    .load1_i (hunt_cap || resync),
    .en_i    (normal),
    .slot_o  (slot)
  );

  // FSM with registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      ch_vld_q   <= '0;
      sync_err_q <= 1'b0;
    end else begin
      ch_vld_q   <= wr_en ? (NUM_SLOTS'(1) << wr_slot) : '0;
      sync_err_q <= resync || loss;
      case (state_q)
        HUNT:    if (hunt_cap) state_q <= LOCKED;
        LOCKED:  if (loss)     state_q <= HUNT;
        default:               state_q <= HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ch_q          <= '0;
    else if (wr_en) ch_q[wr_slot] <= din;
  end

  assign ch_data  = ch_q;
  assign ch_vld   = ch_vld_q;
  assign locked   = (state_q == LOCKED);
  assign sync_err = sync_err_q;

`ifdef TDM_DEMUX_FRAME_EN
  logic [NUM_SLOTS-1:0][W-1:0] frm_q;
  logic                        frm_vld_q;
  logic                        frm_done;

  // In LOCKED every slot-3 capture is preceded by a slot-0 capture (HUNT
  // fsync, resync or aligned fsync), so it always closes a valid frame.
  // Channel registers 0..2 already hold this frame's beats and act as the
  // staging buffer.
  assign frm_done = normal && (slot == SLOT_W'(NUM_SLOTS-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_q     <= '0;
      frm_vld_q <= 1'b0;
    end else begin
      frm_vld_q <= frm_done;
      if (frm_done) frm_q <= {din, ch_q[2], ch_q[1], ch_q[0]};
    end
  end

  assign frm_data = frm_q;
  assign frm_vld  = frm_vld_q;
`else
  assign frm_data = '0;
  assign frm_vld  = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

  localparam int W = 8;
`ifdef TDM_DEMUX_FRAME_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   din = '0;
  logic           din_vld = 1'b0;
  logic           fsync = 1'b0;
  logic [4*W-1:0] ch_data;
  logic [3:0]     ch_vld;
  logic [4*W-1:0] frm_data;
  logic           frm_vld;
  logic           locked;
  logic           sync_err;

  tdm_demux4 #(.W(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .fsync(fsync),
    .ch_data(ch_data), .ch_vld(ch_vld), .frm_data(frm_data),
    .frm_vld(frm_vld), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: spec-level frame alignment
  bit          m_lk;
  int          m_pos;
  logic [7:0]  m_ch[4];
  logic [7:0]  m_stage[4];
  logic [7:0]  m_frm[4];
  logic [3:0]  m_chv;
  bit          m_se, m_fv;

  function automatic void m_reset();
    m_lk = 0; m_pos = 0; m_chv = 0; m_se = 0; m_fv = 0;
    for (int i = 0; i < 4; i++) begin m_ch[i] = 0; m_stage[i] = 0; m_frm[i] = 0; end
  endfunction

  function automatic void m_capture(int s, logic [7:0] d);
    m_ch[s] = d; m_stage[s] = d; m_chv = 4'(1 << s);
  endfunction

  function automatic void m_apply(bit v, bit fs, logic [7:0] d);
    m_chv = 0; m_se = 0; m_fv = 0;
    if (!v) return;
    if (!m_lk) begin
      if (fs) begin m_capture(0, d); m_lk = 1; m_pos = 1; end
    end else if (fs && m_pos != 0) begin
      m_capture(0, d); m_pos = 1; m_se = 1;
    end else if (!fs && m_pos == 0) begin
      m_se = 1; m_lk = 0;
    end else begin
      m_capture(m_pos, d);
      if (m_pos == 3) begin
        m_fv = 1;
        for (int i = 0; i < 4; i++) m_frm[i] = m_stage[i];
      end
      m_pos = (m_pos + 1) % 4;
    end
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    logic [4*W-1:0] exp_frm;
    exp_frm = FE ? {m_frm[3], m_frm[2], m_frm[1], m_frm[0]} : '0;
    chk("ch_data",  64'(ch_data),  64'({m_ch[3], m_ch[2], m_ch[1], m_ch[0]}));
    chk("ch_vld",   64'(ch_vld),   64'(m_chv));
    chk("locked",   64'(locked),   64'(m_lk));
    chk("sync_err", 64'(sync_err), 64'(m_se));
    chk("frm_vld",  64'(frm_vld),  64'(m_fv & FE));
    chk("frm_data", 64'(frm_data), 64'(exp_frm));
  endtask

  task automatic step(bit v, bit fs, logic [7:0] d);
    @(negedge clk);
    din_vld = v; fsync = fs; din = d;
    m_apply(v, fs, d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    din_vld = 0; fsync = 0; rst = 1;
    m_reset();
    @(negedge clk);
    #1;
    chk_model();
    rst = 0;
  endtask

  typedef struct {
    bit         vld;
    bit         fs;
    logic [7:0] d;
    logic [3:0] chv;
    bit         lk;
    bit         se;
    bit         fv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit v, bit fs, logic [7:0] d, logic [3:0] chv, bit lk, bit se, bit fv);
    vec_t r;
    r.vld = v; r.fs = fs; r.d = d; r.chv = chv; r.lk = lk; r.se = se; r.fv = fv;
    return r;
  endfunction

  initial begin
    logic [7:0] gap_d[4];
    int gpos;
    bit v, fs;

    gap_d[0] = 8'hA0; gap_d[1] = 8'hB1; gap_d[2] = 8'hC2; gap_d[3] = 8'hD3;

    // Lock and full frame
    tbl.push_back(mk(1, 1, 8'hA0, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(1, 0, 8'hB1, 4'b0010, 1, 0, 0));
    tbl.push_back(mk(1, 0, 8'hC2, 4'b0100, 1, 0, 0));
    tbl.push_back(mk(1, 0, 8'hD3, 4'b1000, 1, 0, 1));
    // Same frame with 3-cycle gaps
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(mk(1, k == 0, gap_d[k], 4'(1 << k), 1, 0, k == 3));
      for (int g = 0; g < 3; g++) tbl.push_back(mk(0, 0, 8'hFF, 4'b0000, 1, 0, 0));
    end
    // Resync
    tbl.push_back(mk(1, 1, 8'h11, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(1, 0, 8'h22, 4'b0010, 1, 0, 0));
    tbl.push_back(mk(1, 1, 8'h33, 4'b0001, 1, 1, 0));
    tbl.push_back(mk(1, 0, 8'h44, 4'b0010, 1, 0, 0));
    tbl.push_back(mk(1, 0, 8'h55, 4'b0100, 1, 0, 0));
    tbl.push_back(mk(1, 0, 8'h66, 4'b1000, 1, 0, 1));
    // Loss of sync, ignored beats, relock
    tbl.push_back(mk(1, 0, 8'h77, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'h88, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h99, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h04, 4'b0001, 1, 0, 0));

    m_reset();
    do_reset();

    foreach (tbl[i]) begin
      step(tbl[i].vld, tbl[i].fs, tbl[i].d);
      chk("tbl_ch_vld",   64'(ch_vld),   64'(tbl[i].chv));
      chk("tbl_locked",   64'(locked),   64'(tbl[i].lk));
      chk("tbl_sync_err", 64'(sync_err), 64'(tbl[i].se));
      chk("tbl_frm_vld",  64'(frm_vld),  64'(tbl[i].fv & FE));
      chk_model();
      if (i == 3 && FE) chk("frm_abcd", 64'(frm_data), 64'h00000000D3C2B1A0);
      if (i == 25 && FE) chk("frm_resync", 64'(frm_data), 64'h0000000066554433);
      if (i == 22) chk("ch0_resync", 64'(ch_data[7:0]), 64'h33);
    end
    chk("ch0_relock", 64'(ch_data[7:0]), 64'h04);

    // HUNT discard after reset
    do_reset();
    step(1, 0, 8'h01); chk("hunt_chv", 64'(ch_vld), 64'h0); chk("hunt_lk", 64'(locked), 64'h0);
    step(1, 0, 8'h02); chk_model();
    step(1, 0, 8'h03); chk_model();
    step(1, 1, 8'h04); chk("hunt_cap", 64'(ch_data), 64'h04); chk_model();

    // Reset mid-frame, checked before any clock edge
    do_reset();
    step(1, 1, 8'hA5);
    step(1, 0, 8'h5A);
    @(negedge clk);
    din_vld = 0;
    #2 rst = 1;
    #1;
    m_reset();
    chk("rst_async_ch",  64'(ch_data), 64'h0);
    chk("rst_async_chv", 64'(ch_vld),  64'h0);
    chk("rst_async_lk",  64'(locked),  64'h0);
    @(negedge clk);
    rst = 0;
    step(1, 0, 8'h05); chk_model();
    step(1, 0, 8'h06); chk_model();
    chk("rst_ignored", 64'(ch_data), 64'h0);

    // Randomized framing with occasional sync faults and gaps
    do_reset();
    gpos = 0;
    for (int n = 0; n < 3000; n++) begin
      v  = ($urandom_range(3) != 0);
      fs = (gpos == 0);
      if ($urandom_range(15) == 0) fs = ~fs;
      step(v, fs, 8'($urandom));
      chk_model();
      if (v) gpos = (fs && $urandom_range(1) == 0) ? 1 : (gpos + 1) % 4;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
